// File: rtl/arm_ctrl_seq_pkg.sv
// Shared definitions for the ARM-style control sequencer: opcode/mode/ALU
// encodings, decoded-control bundle and sequencer state type.
package arm_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_MOV = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_ADC = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SBC = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_ORR = 4'b0111;
    localparam logic [3:0] ALU_EOR = 4'b1000;
    localparam logic [3:0] ALU_MVN = 4'b1001;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    typedef enum logic [0:0] {
        RUN      = ST_RUN,
        MEM_WAIT = ST_MEM_WAIT
    } ctrl_state_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       branch;
        logic       s_out;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{alu: ALU_NOP, default: 1'b0};

    function automatic logic is_mem(input ctrl_t c);
        return c.mem_read | c.mem_write;
    endfunction

endpackage

// File: rtl/arm_ctrl_seq_if.sv
// Decode-field, handshake and control-output bundle between ID and the
// control sequencer.
interface arm_ctrl_seq_if #(
    parameter int unsigned CMD_W = 4
) ();
    logic             valid_in;
    logic [3:0]       opcode;
    logic [1:0]       mode;
    logic             s_in;
    logic             stall;
    logic             flush;
    logic             mem_ready;
    logic [CMD_W-1:0] alu_command;
    logic             mem_read;
    logic             mem_write;
    logic             wb_en;
    logic             branch;
    logic             s_out;
    logic             illegal;
    logic             valid_out;
    logic             busy;
    logic             mem_err;

    modport master (
        output valid_in, opcode, mode, s_in, stall, flush, mem_ready,
        input  alu_command, mem_read, mem_write, wb_en, branch, s_out,
               illegal, valid_out, busy, mem_err
    );

    modport slave (
        input  valid_in, opcode, mode, s_in, stall, flush, mem_ready,
        output alu_command, mem_read, mem_write, wb_en, branch, s_out,
               illegal, valid_out, busy, mem_err
    );
endinterface

// File: rtl/arm_ctrl_seq_decode.sv
// Purely combinational opcode/mode/S decode into the control bundle.
module arm_ctrl_decode
    import arm_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [1:0] mode_i,
    input  logic       s_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NONE;
        case (mode_i)
            MODE_DP: begin
                ctrl_o.wb_en = 1'b1;
                ctrl_o.s_out = s_i;
                case (opcode_i)
                    OP_MOV:  ctrl_o.alu = ALU_MOV;
                    OP_MVN:  ctrl_o.alu = ALU_MVN;
                    OP_ADD:  ctrl_o.alu = ALU_ADD;
                    OP_ADC:  ctrl_o.alu = ALU_ADC;
                    OP_SUB:  ctrl_o.alu = ALU_SUB;
                    OP_SBC:  ctrl_o.alu = ALU_SBC;
                    OP_AND:  ctrl_o.alu = ALU_AND;
                    OP_ORR:  ctrl_o.alu = ALU_ORR;
                    OP_EOR:  ctrl_o.alu = ALU_EOR;
                    OP_CMP: begin
                        ctrl_o.alu   = ALU_SUB;
                        ctrl_o.wb_en = 1'b0;
                        ctrl_o.s_out = 1'b1;
                    end
                    OP_TST: begin
                        ctrl_o.alu   = ALU_AND;
                        ctrl_o.wb_en = 1'b0;
                        ctrl_o.s_out = 1'b1;
                    end
                    default: begin
                        ctrl_o         = CTRL_NONE;
                        ctrl_o.illegal = 1'b1;
                    end
                endcase
            end
            MODE_MEM: begin
                // S selects LDR (load, writes back) versus STR (store only)
                ctrl_o.alu       = ALU_ADD;
                ctrl_o.mem_read  = s_i;
                ctrl_o.mem_write = ~s_i;
                ctrl_o.wb_en     = s_i;
            end
            MODE_BR: ctrl_o.branch = 1'b1;
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/arm_ctrl_seq.sv
// Registered ID-stage controller: one-cycle decode latency, stall/flush,
// memory-wait sequencing with mem_ready handshake and timeout.
module arm_ctrl_seq
    import arm_pkg::*;
#(
    parameter int unsigned CMD_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    arm_ctrl_seq_if.slave bus
);

    localparam int unsigned      TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t      state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    ctrl_t            dec;
    logic             busy;
    logic             accept;

    arm_ctrl_decode u_decode (
        .opcode_i (bus.opcode),
        .mode_i   (bus.mode),
        .s_i      (bus.s_in),
        .ctrl_o   (dec)
    );

    assign busy   = (state_q == MEM_WAIT) && !bus.mem_ready;
    assign accept = bus.valid_in && !bus.stall && !busy;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (bus.flush) begin
            state_d = RUN;
            tmo_d   = '0;
            ctrl_d  = CTRL_NONE;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (busy) begin
            // stall has no effect while an access is outstanding
            if (tmo_q == TMO_LAST) begin
                state_d = RUN;
                tmo_d   = '0;
                ctrl_d  = CTRL_NONE;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else if (tmo_q < TMO_LAST) begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            // RUN, or MEM_WAIT retiring on mem_ready: same acceptance rules
            state_d = RUN;
            if (accept) begin
                ctrl_d  = dec;
                valid_d = 1'b1;
                if (is_mem(dec)) begin
                    state_d = MEM_WAIT;
                    tmo_d   = '0;
                end
            end else if (!bus.stall) begin
                ctrl_d  = CTRL_NONE;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            tmo_q   <= '0;
            ctrl_q  <= CTRL_NONE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.alu_command = CMD_W'(ctrl_q.alu);
    assign bus.mem_read    = ctrl_q.mem_read;
    assign bus.mem_write   = ctrl_q.mem_write;
    assign bus.wb_en       = ctrl_q.wb_en;
    assign bus.branch      = ctrl_q.branch;
    assign bus.s_out       = ctrl_q.s_out;
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.valid_out   = valid_q;
    assign bus.busy        = busy;
    assign bus.mem_err     = err_q;

endmodule

// File: tb/tb_arm_ctrl_seq.sv
// Scoreboard bench for arm_ctrl_seq: directed scenarios then random traffic
// against a table-driven reference model.
module tb_arm_ctrl_seq;

    localparam int unsigned CMD_W = 6;
    localparam int unsigned TMO   = 4;
    localparam int unsigned W     = CMD_W + 8;

    typedef struct packed {
        logic [3:0] alu;
        logic       rd;
        logic       wr;
        logic       wb;
        logic       br;
        logic       s;
        logic       ill;
        logic       v;
    } out_t;

    typedef struct {
        logic         busy;
        logic [W-1:0] regs;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arm_ctrl_seq_if #(.CMD_W(CMD_W)) bus ();

    arm_ctrl_seq #(.CMD_W(CMD_W), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ALU command per mode-00 opcode index; -1 marks an illegal opcode
    int dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    rec_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    out_t m_out = '0;
    logic m_err = 1'b0;
    int   m_age = -1;   // cycles an outstanding access has waited; -1 = none

    function automatic out_t ref_decode(input logic [3:0] op, input logic [1:0] md,
                                        input logic s);
        out_t o = '0;
        o.v = 1'b1;
        if (md == 2'd0) begin
            if (dp_cmd[op] < 0) begin
                o.ill = 1'b1;
            end else begin
                o.alu = 4'(dp_cmd[op]);
                if (op == 4'd8 || op == 4'd10) o.s = 1'b1;
                else begin
                    o.wb = 1'b1;
                    o.s  = s;
                end
            end
        end else if (md == 2'd1) begin
            o.alu = 4'd2;
            o.rd  = s;
            o.wr  = !s;
            o.wb  = s;
        end else if (md == 2'd2) begin
            o.br = 1'b1;
        end else begin
            o.ill = 1'b1;
        end
        return o;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [3:0] op,
                         input logic [1:0] md, input logic s, input logic st,
                         input logic fl, input logic mr);
        rec_t r;
        rst_n         = rst;
        bus.valid_in  = v;
        bus.opcode    = op;
        bus.mode      = md;
        bus.s_in      = s;
        bus.stall     = st;
        bus.flush     = fl;
        bus.mem_ready = mr;
        r.busy = (m_age >= 0) && !mr;
        if (!rst || fl) begin
            m_out = '0;
            m_err = 1'b0;
            m_age = -1;
        end else if (m_age >= 0 && !mr) begin
            if (m_age == int'(TMO) - 1) begin
                m_out = '0;
                m_err = 1'b1;
                m_age = -1;
            end else begin
                m_age = m_age + 1;
            end
        end else begin
            m_age = -1;
            if (v && !st) begin
                m_out = ref_decode(op, md, s);
                if (m_out.rd || m_out.wr) m_age = 0;
            end else if (!st) begin
                m_out = '0;
            end
        end
        r.regs = {CMD_W'(m_out.alu), m_out.rd, m_out.wr, m_out.wb, m_out.br,
                  m_out.s, m_out.ill, m_out.v, m_err};
        sb.push_back(r);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 4'd0, 2'd0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        rec_t         r;
        logic [W-1:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                vectors++;
                if (bus.busy !== r.busy) begin
                    miscompares++;
                    $display("FAIL busy got %b exp %b at %0t", bus.busy, r.busy, $time);
                end
                @(posedge clk);
                #1;
                act = {bus.alu_command, bus.mem_read, bus.mem_write, bus.wb_en,
                       bus.branch, bus.s_out, bus.illegal, bus.valid_out, bus.mem_err};
                vectors++;
                if (act !== r.regs) begin
                    miscompares++;
                    $display("FAIL regs {alu,rd,wr,wb,br,s,ill,v,err} got %b exp %b at %0t",
                             act, r.regs, $time);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n         = 1'b0;
        bus.valid_in  = 1'b0;
        bus.opcode    = 4'd0;
        bus.mode      = 2'd0;
        bus.s_in      = 1'b0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        drive(0, 0, 4'd0, 2'd0, 0, 0, 0, 0);
        drive(0, 1, 4'd4, 2'd0, 1, 0, 0, 0);          // valid ignored under reset
        drive(1, 1, 4'd4, 2'd0, 1, 0, 0, 0);          // ADD S=1
        drive(1, 1, 4'd10, 2'd0, 0, 0, 0, 0);         // CMP S=0
        drive(1, 1, 4'd3, 2'd0, 1, 0, 0, 0);          // illegal opcode
        drive(1, 1, 4'd9, 2'd3, 1, 0, 0, 0);          // reserved mode
        drive(1, 1, 4'd5, 2'd2, 1, 0, 0, 0);          // branch
        drive(1, 1, 4'd8, 2'd0, 0, 0, 0, 1);          // TST, mem_ready in RUN
        idle(1);
        drive(1, 1, 4'd7, 2'd1, 1, 0, 0, 0);          // LDR
        drive(1, 1, 4'd0, 2'd1, 0, 0, 0, 0);          // STR waits upstream
        drive(1, 1, 4'd0, 2'd1, 0, 1, 0, 0);          // stall ignored while waiting
        drive(1, 1, 4'd0, 2'd1, 0, 0, 0, 1);          // retire + accept STR
        drive(1, 0, 4'd0, 2'd0, 0, 0, 0, 1);          // STR retires k=1
        idle(1);
        drive(1, 1, 4'd2, 2'd1, 0, 0, 0, 0);          // STR timing out
        idle(6);
        drive(1, 0, 4'd0, 2'd0, 0, 0, 1, 0);          // flush clears mem_err
        drive(1, 1, 4'd13, 2'd0, 0, 0, 0, 0);         // MOV
        drive(1, 1, 4'd4, 2'd0, 0, 1, 0, 0);
        drive(1, 1, 4'd4, 2'd0, 0, 1, 0, 0);
        drive(1, 1, 4'd4, 2'd0, 0, 1, 1, 0);          // stall + flush
        drive(1, 1, 4'd1, 2'd1, 1, 0, 0, 0);          // LDR
        drive(1, 0, 4'd0, 2'd0, 0, 0, 1, 1);          // flush beats mem_ready
        drive(1, 1, 4'd1, 2'd1, 1, 0, 0, 0);          // LDR
        drive(1, 0, 4'd0, 2'd0, 0, 0, 0, 0);
        drive(0, 0, 4'd0, 2'd0, 0, 0, 0, 0);          // reset mid-wait
        idle(2);
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(99, 0) >= 2,
                  $urandom_range(99, 0) < 65,
                  4'($urandom),
                  2'($urandom),
                  1'($urandom),
                  $urandom_range(99, 0) < 15,
                  $urandom_range(99, 0) < 4,
                  $urandom_range(99, 0) < 30);
        end
        idle(2);
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
